// File: rtl/rsa_pkg.sv
// Shared types and sizing for the RSA256 byte-stream front-end.
package rsa_pkg;

  localparam int unsigned RSA_W     = 256;
  localparam int unsigned KEY_BYTES = 32;
  localparam int unsigned OUT_BYTES = 31;
  localparam int unsigned OUT_W     = OUT_BYTES * 8;
  localparam int unsigned CNT_W     = 6;

  typedef enum logic [2:0] {
    StGetN,
    StGetD,
    StGetA,
    StStart,
    StWait,
    StSend
  } state_e;

endpackage

// File: rtl/rsa_byte_packer.sv
// 256-bit MSB-first byte shift-in register with load-enable and synchronous clear.
module rsa_byte_packer
  import rsa_pkg::*;
(
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [7:0]       data_i,
  output logic [RSA_W-1:0] q_o
);

  logic [RSA_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (en_i) begin
      q_d = {q_q[RSA_W-9:0], data_i};
    end
  end

  always_ff @(posedge clk_i) begin
    q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/rsa_stream_ctrl.sv
// Byte-stream controller: loads N, D, then ciphertext blocks, runs the core and
// streams the low 248 result bits back out MSB first.
module rsa_stream_ctrl
  import rsa_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [7:0]       i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic [7:0]       o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_core_start,
  output logic [RSA_W-1:0] o_core_a,
  output logic [RSA_W-1:0] o_core_d,
  output logic [RSA_W-1:0] o_core_n,
  input  logic [RSA_W-1:0] i_core_result,
  input  logic             i_core_finished
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   out_sr_q, out_sr_d;

  logic in_fire, out_fire, last_key, last_out;

  assign o_in_ready   = (state_q == StGetN) || (state_q == StGetD) || (state_q == StGetA);
  assign o_out_valid  = (state_q == StSend);
  assign o_core_start = (state_q == StStart);
  assign o_out_data   = out_sr_q[OUT_W-1 -: 8];

  assign in_fire  = i_in_valid && o_in_ready;
  assign out_fire = o_out_valid && i_out_ready;
  assign last_key = (cnt_q == CNT_W'(KEY_BYTES - 1));
  assign last_out = (cnt_q == CNT_W'(OUT_BYTES - 1));

  always_comb begin
    state_d  = state_q;
    out_sr_d = out_sr_q;
    unique case (state_q)
      StGetN:  if (in_fire && last_key) state_d = StGetD;
      StGetD:  if (in_fire && last_key) state_d = StGetA;
      StGetA:  if (in_fire && last_key) state_d = StStart;
      StStart: state_d = StWait;
      StWait: begin
        if (i_core_finished) begin
          out_sr_d = i_core_result[OUT_W-1:0];
          state_d  = StSend;
        end
      end
      StSend: begin
        if (out_fire) begin
          out_sr_d = out_sr_q << 8;
          if (last_out) state_d = StGetA;
        end
      end
      default: state_d = StGetN;
    endcase
  end

  // The counter restarts whenever the state moves, so each phase counts from 0.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (in_fire || out_fire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= StGetN;
      cnt_q    <= '0;
      out_sr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_sr_q <= out_sr_d;
    end
  end

  rsa_byte_packer u_pack_n (
    .clk_i  (i_clk),
    .clr_i  (!i_rst_n),
    .en_i   (in_fire && (state_q == StGetN)),
    .data_i (i_in_data),
    .q_o    (o_core_n)
  );

  rsa_byte_packer u_pack_d (
    .clk_i  (i_clk),
    .clr_i  (!i_rst_n),
    .en_i   (in_fire && (state_q == StGetD)),
    .data_i (i_in_data),
    .q_o    (o_core_d)
  );

  rsa_byte_packer u_pack_a (
    .clk_i  (i_clk),
    .clr_i  (!i_rst_n),
    .en_i   (in_fire && (state_q == StGetA)),
    .data_i (i_in_data),
    .q_o    (o_core_a)
  );

endmodule

// File: tb/tb_rsa_stream_ctrl.sv
// Self-checking bench for rsa_stream_ctrl with a stub core and an output scoreboard.
module tb_rsa_stream_ctrl;
  import rsa_pkg::*;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic [7:0]   i_in_data = 8'h00;
  logic         i_in_valid = 1'b0;
  logic         o_in_ready;
  logic [7:0]   o_out_data;
  logic         o_out_valid;
  logic         i_out_ready = 1'b1;
  logic         o_core_start;
  logic [255:0] o_core_a, o_core_d, o_core_n;
  logic [255:0] i_core_result = '0;
  logic         i_core_finished;
  logic         stub_fin = 1'b0;
  logic         spur_fin = 1'b0;

  assign i_core_finished = stub_fin | spur_fin;

  rsa_stream_ctrl dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_in_data       (i_in_data),
    .i_in_valid      (i_in_valid),
    .o_in_ready      (o_in_ready),
    .o_out_data      (o_out_data),
    .o_out_valid     (o_out_valid),
    .i_out_ready     (i_out_ready),
    .o_core_start    (o_core_start),
    .o_core_a        (o_core_a),
    .o_core_d        (o_core_d),
    .o_core_n        (o_core_n),
    .i_core_result   (i_core_result),
    .i_core_finished (i_core_finished)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [255:0] a;
    logic [255:0] res;
    bit           bp;
    bit           gaps;
    bit           hold;
    bit           spur;
  } vec_t;

  vec_t         vecs[4];
  logic [7:0]   sb[$];
  int           n_tests = 0;
  int           n_fail = 0;
  int           hs_cnt = 0;
  int           acc_cnt = 0;
  int           exp_acc = 0;
  int           start_cnt = 0;
  int           ph = 0;
  bit           out_bp = 1'b0;
  bit           stalled = 1'b0;
  logic [7:0]   prev_data = 8'h00;
  logic [255:0] exp_n = '0, exp_d = '0, cur_a = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mk_seq(input logic [7:0] first);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) v[255-8*i -: 8] = first + 8'(i);
    return v;
  endfunction

  // Downstream ready: always high, or the 1,0,0,1 backpressure pattern.
  always begin
    @(posedge i_clk);
    #1;
    i_out_ready = !out_bp || (ph == 0) || (ph == 3);
    ph = (ph + 1) % 4;
  end

  // Output monitor / scoreboard consumer, sampled at the falling edge.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      stalled = 1'b0;
    end else begin
      if (i_in_valid && o_in_ready) acc_cnt++;
      if (stalled) begin
        check("stall_valid", {255'd0, o_out_valid}, 256'd1);
        check("stall_data", {248'd0, o_out_data}, {248'd0, prev_data});
      end
      if (o_out_valid && i_out_ready) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got %h want none", o_out_data);
        end else begin
          check("out_byte", {248'd0, o_out_data}, {248'd0, sb.pop_front()});
        end
      end
      stalled   = o_out_valid && !i_out_ready;
      prev_data = o_out_data;
    end
  end

  // Stub core: finished pulse 10 cycles after start.
  always begin
    @(negedge i_clk);
    if (i_rst_n && o_core_start) begin
      start_cnt++;
      repeat (10) @(posedge i_clk);
      #1;
      stub_fin = 1'b1;
      check("hold_a", o_core_a, cur_a);
      check("hold_n", o_core_n, exp_n);
      check("hold_d", o_core_d, exp_d);
      @(posedge i_clk);
      #1;
      stub_fin = 1'b0;
      check("fin_valid", {255'd0, o_out_valid}, 256'd1);
      if (sb.size() != 0) check("fin_first", {248'd0, o_out_data}, {248'd0, sb[0]});
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok;
    ok = 1'b0;
    if (gaps) begin
      i_in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge i_clk);
        #1;
      end
    end
    i_in_data  = b;
    i_in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      ok = o_in_ready;
      @(posedge i_clk);
      #1;
      if (ok) break;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL in_timeout: got ready 0 want 1");
    end
    i_in_valid = 1'b0;
  endtask

  task automatic send_key(input logic [255:0] n, input logic [255:0] d);
    for (int i = 0; i < 32; i++) send_byte(n[255-8*i -: 8], 1'b0);
    for (int i = 0; i < 32; i++) send_byte(d[255-8*i -: 8], 1'b0);
    exp_n = n;
    exp_d = d;
    exp_acc += 64;
  endtask

  task automatic run_block(input vec_t v);
    int hs_base, st_base, t;
    hs_base       = hs_cnt;
    st_base       = start_cnt;
    out_bp        = v.bp;
    cur_a         = v.a;
    i_core_result = v.res;
    for (int i = 0; i < 31; i++) sb.push_back(v.res[247-8*i -: 8]);
    for (int i = 0; i < 32; i++) begin
      send_byte(v.a[255-8*i -: 8], v.gaps);
      if (v.spur && i == 4) begin
        spur_fin = 1'b1;
        @(posedge i_clk);
        #1;
        spur_fin = 1'b0;
        check("spur_geta_ready", {255'd0, o_in_ready}, 256'd1);
        check("spur_geta_valid", {255'd0, o_out_valid}, 256'd0);
      end
    end
    exp_acc += 32;
    check("start_pulse", {255'd0, o_core_start}, 256'd1);
    check("core_a", o_core_a, v.a);
    check("core_n", o_core_n, exp_n);
    check("core_d", o_core_d, exp_d);
    if (v.hold) begin
      i_in_data  = 8'hEE;
      i_in_valid = 1'b1;
    end
    if (v.spur) spur_fin = 1'b1;
    @(posedge i_clk);
    #1;
    spur_fin = 1'b0;
    check("start_end", {255'd0, o_core_start}, 256'd0);
    check("wait_valid", {255'd0, o_out_valid}, 256'd0);
    for (t = 0; t < 3000; t++) begin
      @(posedge i_clk);
      #1;
      if (sb.size() == 0) break;
      if (v.hold) check("hold_ready", {255'd0, o_in_ready}, 256'd0);
    end
    i_in_valid = 1'b0;
    if (t == 3000) begin
      n_tests++;
      n_fail++;
      $display("FAIL block_timeout: got %0d bytes left want 0", sb.size());
      sb.delete();
    end
    check("done_valid", {255'd0, o_out_valid}, 256'd0);
    check("done_ready", {255'd0, o_in_ready}, 256'd1);
    check("hs_count", 256'(hs_cnt - hs_base), 256'd31);
    check("start_count", 256'(start_cnt - st_base), 256'd1);
    check("accepted", 256'(acc_cnt), 256'(exp_acc));
    check("keep_n", o_core_n, exp_n);
    check("keep_d", o_core_d, exp_d);
  endtask

  initial begin
    int t;
    vecs[0] = '{a: mk_seq(8'h40), res: mk_seq(8'h00), bp: 0, gaps: 0, hold: 0, spur: 0};
    vecs[1] = '{a: {256{1'b1}}, res: {32{8'hAA}}, bp: 0, gaps: 0, hold: 0, spur: 0};
    vecs[2] = '{a: {8{32'h1234_5678}}, res: mk_seq(8'h80), bp: 1, gaps: 1, hold: 0, spur: 0};
    vecs[3] = '{a: mk_seq(8'hC0), res: {8{32'hDEAD_BEEF}}, bp: 1, gaps: 0, hold: 1, spur: 1};

    repeat (2) @(posedge i_clk);
    #1;
    check("rst_valid", {255'd0, o_out_valid}, 256'd0);
    check("rst_start", {255'd0, o_core_start}, 256'd0);
    check("rst_data", {248'd0, o_out_data}, 256'd0);
    check("rst_n_reg", o_core_n, 256'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    check("rst_ready", {255'd0, o_in_ready}, 256'd1);

    send_key(mk_seq(8'h00), mk_seq(8'h20));
    for (int i = 0; i < 4; i++) run_block(vecs[i]);

    // Reset while byte 10 of a block is on the output.
    out_bp = 1'b0;
    cur_a  = vecs[1].a;
    i_core_result = vecs[1].res;
    for (int i = 0; i < 31; i++) sb.push_back(vecs[1].res[247-8*i -: 8]);
    t = hs_cnt;
    for (int i = 0; i < 32; i++) send_byte(vecs[1].a[255-8*i -: 8], 1'b0);
    exp_acc += 32;
    for (int c = 0; c < 200; c++) begin
      @(posedge i_clk);
      #1;
      if (hs_cnt - t >= 10) break;
    end
    check("pre_rst_hs", 256'(hs_cnt - t), 256'd10);
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    check("mid_rst_valid", {255'd0, o_out_valid}, 256'd0);
    check("mid_rst_state", {253'd0, dut.state_q}, {253'd0, StGetN});
    check("mid_rst_n", o_core_n, 256'd0);
    check("mid_rst_d", o_core_d, 256'd0);
    check("mid_rst_a", o_core_a, 256'd0);
    check("mid_rst_data", {248'd0, o_out_data}, 256'd0);
    i_rst_n = 1'b1;
    sb.delete();
    exp_n = '0;
    exp_d = '0;
    @(posedge i_clk);
    #1;
    check("post_rst_ready", {255'd0, o_in_ready}, 256'd1);

    send_key(mk_seq(8'h00), mk_seq(8'h20));
    run_block(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rsa_stream_ctrl.md
# rsa_stream_ctrl

Byte-stream front-end controller for the RSA256 decryption core. Accepts a byte stream carrying the modulus N, the private exponent D, and then any number of 256-bit ciphertext blocks. For each block it pulses a start to the core, waits for the core's finished flag, and streams the plaintext back out as bytes. It is the initiator side of the core's start/finished interface and sits between the serial I/O (UART/bus bridge) and the core at the top level.

## Interface
- KEY_BYTES, 32: bytes per 256-bit operand (N, D, ciphertext A).
- OUT_BYTES, 31: plaintext bytes emitted per block, taken from the low 248 bits of the result.
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_in_data  in  8  input byte.
- i_in_valid  in  1  input byte valid.
- o_in_ready  out  1  controller accepts a byte this cycle.
- o_out_data  out  8  output plaintext byte.
- o_out_valid  out  1  output byte valid.
- i_out_ready  in  1  downstream accepts the output byte.
- o_core_start  out  1  one-cycle start pulse to the core.
- o_core_a  out  256  ciphertext operand.
- o_core_d  out  256  exponent operand.
- o_core_n  out  256  modulus operand.
- i_core_result  in  256  core result, a^d mod n.
- i_core_finished  in  1  core done pulse.

## Operation
- States: GET_N, GET_D, GET_A, START, WAIT, SEND.
- Reset values: state GET_N; byte counter 0; N, D, A and output shift registers 0; o_core_start 0; o_out_valid 0; o_out_data 0.
- Byte transfer: a byte is accepted when i_in_valid && o_in_ready.
- o_in_ready is 1 only in GET_N, GET_D and GET_A, and is decoded from registered state only.
- Operand assembly: bytes arrive MSB first. Each accepted byte is shifted in as reg <= {reg[247:0], i_in_data}.
- Byte counter: 6 bits, clears on every state change.
- GET_N -> GET_D, GET_D -> GET_A, and GET_A -> START each occur on the handshake of byte KEY_BYTES-1.
- START: o_core_start = 1 for exactly one cycle, then WAIT.
- WAIT: on i_core_finished, latch i_core_result[247:0] into the output shift register, then go to SEND.
- SEND: o_out_data = out_sr[247:240].
  - On each o_out_valid && i_out_ready handshake: shift left 8 and increment the counter.
  - On the handshake of byte OUT_BYTES-1, go to GET_A.
- Key retention: N and D persist across blocks. Only a reset returns the controller to GET_N.
- i_core_finished is ignored in every state except WAIT.
- o_core_a, o_core_d and o_core_n are driven directly from their registers. They must be stable from START until WAIT exits.

## Timing
- Last A byte accepted at edge k: o_core_start is high in cycle k+1, and WAIT holds from cycle k+2.
- i_core_finished sampled high at edge j: o_out_valid = 1 from cycle j+1, with the first byte already on o_out_data.
- Output backpressure: o_out_data and o_out_valid hold stable while o_out_valid && !i_out_ready.
- o_out_valid is continuously 1 throughout SEND. There are no bubbles when i_out_ready is held high, so a block drains in exactly OUT_BYTES cycles.
- After the last output handshake, o_out_valid = 0 and o_in_ready = 1 in the next cycle.
- i_in_valid asserted outside the GET states: not accepted. The byte stays pending upstream.
- Reset asserted mid-operation (any state): takes effect at the next edge. o_core_start is forced to 0 that same edge, and any in-flight output byte is dropped.

## Structure
- Shared package rsa_pkg holds:
  - the state enum;
  - KEY_BYTES, OUT_BYTES;
  - RSA_W = 256.
- One sub-module, rsa_byte_packer: 256-bit shift-in register with load-enable and clear. It is instantiated three times (N, D, A).
- FSM, counter, output shift register and handshakes stay in rsa_stream_ctrl.

## Test plan
- Key + block: send N = bytes 0x00..0x1F, D = 0x20..0x3F, A = 0x40..0x5F, with the stub core returning 0x000102…1F after 10 cycles.
  - Required: o_core_n = 0x0001…1F, o_core_d = 0x2021…3F, o_core_a = 0x4041…5F.
  - Required: exactly one start pulse, one cycle after byte 0x5F.
  - Required: output bytes 0x01..0x1F, 31 total, in order.
- Second block, no key resend: send A = 32×0xFF, with the stub core returning all-0xAA.
  - Required: N and D unchanged.
  - Required: 31 bytes of 0xAA out.
- Output backpressure: i_out_ready toggles 1,0,0,1 repeatedly during SEND.
  - Required: data holds while stalled, no byte is lost or duplicated, and 31 handshakes occur.
- Input gaps and illegal timing:
  - i_in_valid with random gaps: still exactly 32 bytes per operand.
  - i_in_valid held high during WAIT/SEND: o_in_ready = 0 and no bytes are absorbed.
- Spurious finished: i_core_finished pulsed in GET_A and in START.
  - Required: ignored; state unchanged and no output.
- Reset mid-operation: assert i_rst_n = 0 for one cycle during SEND byte 10.
  - Required next cycle: o_out_valid = 0, state GET_N, registers 0.
  - Required after a full reload: normal operation.
